// File: rtl/conv_layer_ctrl_if.sv
// Handshake and datapath-control bundle between conv_layer_ctrl and its host/filter_n2 neighbours.
// master: the sequencer; slave: host FSM, line buffer and filter_n2 side.
interface conv_layer_ctrl_if #(
  parameter int unsigned AW   = 10,
  parameter int unsigned IDXW = 2
);
  logic            start;
  logic            cfg_relu;
  logic            cfg_clip;
  logic [7:0]      cfg_relu_c;
  logic            relu;
  logic            clip;
  logic [7:0]      relu_c;
  logic            busy;
  logic            done;
  logic            w_ld_en;
  logic [IDXW-1:0] w_ld_idx;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic            pipe_en;
  logic            out_ready;
  logic            out_valid;
  logic [7:0]      out_row;
  logic [7:0]      out_col;
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_stalls;

  modport master (
    input  start, cfg_relu, cfg_clip, cfg_relu_c, out_ready,
    output relu, clip, relu_c, busy, done, w_ld_en, w_ld_idx,
           win_valid, win_addr, pipe_en, out_valid, out_row, out_col,
           perf_cycles, perf_stalls
  );

  modport slave (
    output start, cfg_relu, cfg_clip, cfg_relu_c, out_ready,
    input  relu, clip, relu_c, busy, done, w_ld_en, w_ld_idx,
           win_valid, win_addr, pipe_en, out_valid, out_row, out_col,
           perf_cycles, perf_stalls
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Convolution-layer sequencer: weight load, raster window issue, latency-tracked result tagging.
// Optional busy/stall counters are built when CONV_LAYER_CTRL_PERF_EN is defined.
module conv_layer_ctrl #(
  parameter int unsigned IMG_W    = 28,
  parameter int unsigned IMG_H    = 28,
  parameter int unsigned FN       = 3,
  parameter int unsigned N1       = 1,
  parameter int unsigned N2       = 4,
  parameter int unsigned FILT_LAT = 3,
  parameter int unsigned AW       = 10
) (
  input logic clk,
  input logic reset,
  conv_layer_ctrl_if.master bus
);
  localparam int unsigned OW    = IMG_W - FN + 1;
  localparam int unsigned OH    = IMG_H - FN + 1;
  localparam int unsigned NSLOT = N1 * N2;
  localparam int unsigned IDXW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, SCAN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      row_q, row_d, col_q, col_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            relu_q, relu_d, clip_q, clip_d;
  logic [7:0]      relu_c_q, relu_c_d;

  logic [FILT_LAT-1:0] vld_q;
  logic [7:0]          prow_q [FILT_LAT];
  logic [7:0]          pcol_q [FILT_LAT];

  logic out_valid, pipe_en, win_valid, last_win, early_vld;

  assign out_valid = vld_q[FILT_LAT-1];
  assign pipe_en   = !(out_valid && !bus.out_ready);
  assign win_valid = (state_q == SCAN);
  assign last_win  = (row_q == 8'(OH - 1)) && (col_q == 8'(OW - 1));

  // Anything still in flight ahead of the output stage keeps DRAIN waiting.
  always_comb begin
    early_vld = 1'b0;
    for (int unsigned i = 0; i + 1 < FILT_LAT; i++) early_vld = early_vld | vld_q[i];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    relu_d   = relu_q;
    clip_d   = clip_q;
    relu_c_d = relu_c_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD_W;
          idx_d    = '0;
          row_d    = '0;
          col_d    = '0;
          addr_d   = '0;
          relu_d   = bus.cfg_relu;
          clip_d   = bus.cfg_clip;
          relu_c_d = bus.cfg_relu_c;
        end
      end
      LOAD_W: begin
        if (idx_q == IDXW'(NSLOT - 1)) begin
          state_d = SCAN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      SCAN: begin
        if (pipe_en) begin
          if (last_win) begin
            state_d = DRAIN;
          end else if (col_q == 8'(OW - 1)) begin
            // Row wrap: skipping the FN-1 columns that cannot host a full window.
            col_d  = '0;
            row_d  = row_q + 8'd1;
            addr_d = addr_q + AW'(FN);
          end else begin
            col_d  = col_q + 8'd1;
            addr_d = addr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (!early_vld && (!out_valid || bus.out_ready)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      relu_q   <= 1'b0;
      clip_q   <= 1'b0;
      relu_c_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      relu_q   <= relu_d;
      clip_q   <= clip_d;
      relu_c_q <= relu_c_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < FILT_LAT; i++) begin
        prow_q[i] <= '0;
        pcol_q[i] <= '0;
      end
    end else if (pipe_en) begin
      vld_q[0]  <= win_valid;
      prow_q[0] <= row_q;
      pcol_q[0] <= col_q;
      for (int unsigned i = 1; i < FILT_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prow_q[i] <= prow_q[i-1];
        pcol_q[i] <= pcol_q[i-1];
      end
    end
  end

  assign bus.relu      = relu_q;
  assign bus.clip      = clip_q;
  assign bus.relu_c    = relu_c_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.w_ld_en   = (state_q == LOAD_W);
  assign bus.w_ld_idx  = idx_q;
  assign bus.win_valid = win_valid;
  assign bus.win_addr  = addr_q;
  assign bus.pipe_en   = pipe_en;
  assign bus.out_valid = out_valid;
  assign bus.out_row   = prow_q[FILT_LAT-1];
  assign bus.out_col   = pcol_q[FILT_LAT-1];

`ifdef CONV_LAYER_CTRL_PERF_EN
  logic [31:0] perf_cyc_q, perf_stl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else if (state_q != IDLE) begin
      perf_cyc_q <= perf_cyc_q + 32'd1;
      if (!pipe_en) perf_stl_q <= perf_stl_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cyc_q;
  assign bus.perf_stalls = perf_stl_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Randomized bench for conv_layer_ctrl, checked against a cycle-indexed arithmetic model of a layer run.
module tb_conv_layer_ctrl;
  localparam int IMG_W = 6, IMG_H = 5, FN = 3, N1 = 2, N2 = 2, FILT_LAT = 3, AW = 10, IDXW = 2;
  localparam int OW = IMG_W - FN + 1;
  localparam int OH = IMG_H - FN + 1;
  localparam int NWIN = OW * OH;
  localparam int NSLOT = N1 * N2;

  logic clk = 1'b0;
  logic reset;

  conv_layer_ctrl_if #(.AW(AW), .IDXW(IDXW)) bus ();

  conv_layer_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FN(FN), .N1(N1), .N2(N2), .FILT_LAT(FILT_LAT), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic       exp_relu, exp_clip;
  logic [7:0] exp_relu_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cfg();
    check_eq("relu", bus.relu, exp_relu);
    check_eq("clip", bus.clip, exp_clip);
    check_eq("relu_c", bus.relu_c, exp_relu_c);
  endtask

  // mode 0: always ready, 1: 5-cycle stall at 3rd result, 2: random ready, 3: reset mid-SCAN
  task automatic run(input int mode, output int cycles_o, output int stalls_o, output bit aborted_o);
    int cyc, en_cnt, acc, stall_left, stalls, ri;
    bit fin, stalled_once, ld, sc, wv, ov, dn, rdy, pe;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.cfg_relu   = (mode == 1) ? 1'b1 : 1'($urandom);
    bus.cfg_clip   = 1'($urandom);
    bus.cfg_relu_c = (mode == 1) ? 8'h10 : 8'($urandom);
    exp_relu   = bus.cfg_relu;
    exp_clip   = bus.cfg_clip;
    exp_relu_c = bus.cfg_relu_c;
    cyc = 0; en_cnt = 0; acc = 0; stall_left = 0; stalls = 0;
    fin = 1'b0; stalled_once = 1'b0; aborted_o = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.start      = (cyc == NSLOT + 3);
      bus.cfg_relu   = 1'($urandom);
      bus.cfg_clip   = 1'($urandom);
      bus.cfg_relu_c = 8'($urandom);
      ld = (cyc <= NSLOT);
      sc = (cyc > NSLOT) && (acc < NWIN);
      wv = sc && (en_cnt < NWIN);
      ri = en_cnt - FILT_LAT;
      ov = sc && (ri >= 0) && (ri < NWIN);
      dn = (cyc > NSLOT) && (acc == NWIN);
      if (mode == 1 && ov && ri == 2 && !stalled_once) begin
        stall_left   = 5;
        stalled_once = 1'b1;
      end
      case (mode)
        1:       rdy = (stall_left == 0);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      if (stall_left > 0) stall_left--;
      bus.out_ready = rdy;
      pe = !(ov && !rdy);
      if (mode == 3 && cyc == NSLOT + 6) begin
        reset = 1'b1;
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_win_valid", bus.win_valid, 0);
        check_eq("rst_done", bus.done, 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        exp_relu = 1'b0; exp_clip = 1'b0; exp_relu_c = 8'h00;
        aborted_o = 1'b1;
        fin = 1'b1;
      end else begin
        #1;
        check_eq("busy", bus.busy, 1);
        check_eq("done", bus.done, dn);
        check_eq("w_ld_en", bus.w_ld_en, ld);
        if (ld) check_eq("w_ld_idx", bus.w_ld_idx, cyc - 1);
        check_eq("win_valid", bus.win_valid, wv);
        if (wv) check_eq("win_addr", bus.win_addr, (en_cnt / OW) * IMG_W + (en_cnt % OW));
        check_eq("out_valid", bus.out_valid, ov);
        if (ov) begin
          check_eq("out_row", bus.out_row, ri / OW);
          check_eq("out_col", bus.out_col, ri % OW);
        end
        check_eq("pipe_en", bus.pipe_en, pe);
        check_cfg();
        if (!pe) stalls++;
        if (sc && pe) en_cnt++;
        if (ov && rdy) acc++;
        if (dn) fin = 1'b1;
      end
    end
    if (!fin) check_eq("timeout", 0, 1);
    if (!aborted_o) check_eq("run_len", cyc, NSLOT + NWIN + FILT_LAT + 1 + stalls);
    if (mode == 0) check_eq("run_len_nostall", cyc, 20);
    if (mode == 1) check_eq("run_len_stall", cyc, 25);
    bus.start = 1'b0;
    cycles_o  = cyc;
    stalls_o  = stalls;
  endtask

  task automatic idle_check(input int cyc_exp, input int stl_exp);
    repeat (2) begin
      @(negedge clk);
      bus.cfg_relu   = 1'($urandom);
      bus.cfg_relu_c = 8'($urandom);
      #1;
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_done", bus.done, 0);
      check_eq("idle_win_valid", bus.win_valid, 0);
      check_eq("idle_out_valid", bus.out_valid, 0);
      check_eq("idle_pipe_en", bus.pipe_en, 1);
      check_cfg();
    end
`ifdef CONV_LAYER_CTRL_PERF_EN
    check_eq("perf_cycles", bus.perf_cycles, cyc_exp);
    check_eq("perf_stalls", bus.perf_stalls, stl_exp);
`else
    check_eq("perf_cycles_tied", bus.perf_cycles, 0);
    check_eq("perf_stalls_tied", bus.perf_stalls, 0);
    if (cyc_exp < 0 || stl_exp < 0) check_eq("perf_args", 0, 1);
`endif
  endtask

  initial begin
    int cyc, stl;
    bit ab;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.cfg_relu   = 1'b0;
    bus.cfg_clip   = 1'b0;
    bus.cfg_relu_c = 8'h00;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_w_ld_en", bus.w_ld_en, 0);
    check_eq("rst_w_ld_idx", bus.w_ld_idx, 0);
    check_eq("rst_win_valid", bus.win_valid, 0);
    check_eq("rst_win_addr", bus.win_addr, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_row", bus.out_row, 0);
    check_eq("rst_out_col", bus.out_col, 0);
    check_eq("rst_relu", bus.relu, 0);
    check_eq("rst_clip", bus.clip, 0);
    check_eq("rst_relu_c", bus.relu_c, 0);
    check_eq("rst_pipe_en", bus.pipe_en, 1);
    reset = 1'b0;

    run(0, cyc, stl, ab); idle_check(cyc, stl);
    run(1, cyc, stl, ab); idle_check(cyc, stl);
    run(3, cyc, stl, ab); idle_check(0, 0);
    run(0, cyc, stl, ab); idle_check(cyc, stl);
    for (int r = 0; r < 4; r++) begin
      run(2, cyc, stl, ab);
      idle_check(cyc, stl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Sequencer for one convolution layer built from the `filter_n2` bank, which has N2 output filters of N1 input channels each with an FN×FN window. Per run it latches the activation configuration, steps the weight loader through every filter/channel slot, then raster-scans all valid output positions. It issues one window base address per cycle to the line buffer / feature-map memory and tracks the datapath latency so each result leaves with its coordinates. It sits between the layer-level host FSM and the `filter_n2` datapath and owns the datapath clock enable.

## Interface
- IMG_W, 28, input feature-map width in pixels
- IMG_H, 28, input feature-map height in pixels
- FN, 3, filter window size
- N1, 1, input channels
- N2, 4, output filters
- FILT_LAT, 3, `filter_n2` pipeline latency in enabled cycles (≥1)
- AW, 10, window address width (≥ clog2(IMG_W*IMG_H))

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- cfg_relu, cfg_clip  in  1 each  activation config, latched at accepted start
- cfg_relu_c  in  8  ReLU constant, latched at accepted start
- relu, clip  out  1 each  latched config to datapath
- relu_c  out  8  latched config to datapath
- busy  out  1  high from LOAD_W through DONE
- done  out  1  one-cycle pulse at run end
- w_ld_en  out  1  weight-slot load strobe
- w_ld_idx  out  clog2(N1*N2)  slot index, m*N1+k
- win_valid  out  1  window address valid
- win_addr  out  AW  top-left pixel address, row*IMG_W+col
- pipe_en  out  1  datapath clock enable
- out_ready  in  1  downstream accepts result
- out_valid  out  1  result at `filter_n2` outputs is valid
- out_row, out_col  out  8 each  coordinates of current result

## Operation
- OW = IMG_W-FN+1, OH = IMG_H-FN+1, NWIN = OW*OH. Stride 1, no padding.
- States:
  - IDLE: `start` goes to LOAD_W and latches cfg_*.
  - LOAD_W: `w_ld_en`=1 and `w_ld_idx` counts 0..N1*N2-1, one per cycle. Goes to SCAN after the last slot.
  - SCAN: issues windows col-fastest. (0,0),(0,1)..(0,OW-1),(1,0)..(OH-1,OW-1). Goes to DRAIN after the issue of window NWIN-1 is enabled.
  - DRAIN: waits until the valid pipeline is empty and the last result is accepted, then goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `pipe_en` = !(out_valid && !out_ready). It is 1 in IDLE and LOAD_W.
- In SCAN, the issue counter advances and `win_valid` shifts only when `pipe_en`=1. During a stall `win_valid`, `win_addr` and the row/col counters hold.
- Valid/tag pipeline: FILT_LAT-stage shift register of {win_valid,row,col}, advanced by `pipe_en`. The final stage drives out_valid/out_row/out_col.
- `start` while busy is ignored. Config outputs hold constant through the run and keep their value in IDLE.
- `win_addr` is computed incrementally (+1 per column, +FN at row wrap). No multiplier.
- Reset at any point: state IDLE, all counters and the valid pipeline cleared; the run is abandoned and no `done` is issued.

## Timing
- Reset values: busy=0, done=0, w_ld_en=0, w_ld_idx=0, win_valid=0, win_addr=0, out_valid=0, out_row=0, out_col=0, relu=0, clip=0, relu_c=0, pipe_en=1.
- Cycle timing with no stalls:
  - `start` high at edge t → busy=1 and w_ld_en=1 from t+1 to t+N1*N2.
  - SCAN window 0 at t+N1*N2+1.
  - First out_valid at t+N1*N2+1+FILT_LAT.
  - Last out_valid at t+N1*N2+NWIN+FILT_LAT.
  - `done` on the next cycle; busy drops with it.
- Total run = N1*N2 + NWIN + FILT_LAT + 1 cycles + stall cycles.
- out_valid/out_row/out_col are stable while out_valid && !out_ready.

## Configuration
- `CONV_LAYER_CTRL_PERF_EN` defined:
  - adds output `perf_cycles` [31:0] counting busy cycles of the current run, cleared at accepted start and held after done;
  - adds output `perf_stalls` [31:0] counting cycles with busy && !pipe_en.
- Undefined: both ports are present and tied to 0, and no counter logic is built.

## Test plan
- IMG_W=6, IMG_H=5, FN=3, N1=2, N2=2, FILT_LAT=3; start pulse → 4 w_ld_en cycles with idx 0,1,2,3, then 12 windows with win_addr 0,1,2,3,6,7,8,9,12,13,14,15; done after 12 results, total 20 cycles.
- Same config; out_ready low for 5 cycles at the 3rd result → out_valid held with (0,2), win_addr frozen, no result lost or duplicated, done 5 cycles later.
- cfg_relu=1, cfg_relu_c=8'h10 latched at start; change cfg_* mid-run → relu=1, relu_c=8'h10 unchanged until the next start.
- start reasserted during SCAN → ignored; exactly one done.
- reset asserted mid-SCAN → same-cycle busy=0, out_valid=0, win_valid=0; a new start then runs a full, correct sequence.
- With PERF_EN, the stall test → perf_cycles=25, perf_stalls=5.
